tick_generator: RTL and testbench
=================================

TICK_GENERATOR -- requirements
Module: tick_generator

Interface
REQ-001 SHALL have parameter nrOfBits, default 16, width of the divider counter and reload value.
REQ-002 SHALL have parameter reloadValue, default 9999, reset reload value; tick period = reload+1 cycles.
REQ-003 SHALL have parameter tickCountBits, default 8, width of tickCount.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port s_clock  input  1  clock; all state updates on rising edge.
REQ-006 SHALL have port run  input  1  level; 1 = free-running ticks, 0 = stopped.
REQ-007 SHALL have port step  input  1  single-step request; rising edge detected internally.
REQ-008 SHALL have port load  input  1  1 = capture loadValue into reload register.
REQ-009 SHALL have port loadValue  input  nrOfBits  new reload value.
REQ-010 SHALL have port clearCount  input  1  synchronous clear of tickCount.
REQ-011 SHALL have port tick  output  1  registered one-cycle clock-enable pulse, fed to the tick input of downstream registers.
REQ-012 SHALL have port running  output  1  1 while in state RUNNING.
REQ-013 SHALL have port tickCount  output  tickCountBits  number of ticks issued, modulo 2^tickCountBits.

Function
REQ-014 SHALL implement two states, STOPPED and RUNNING; running = (state == RUNNING).
REQ-015 STOPPED -> RUNNING at an edge where run=1; RUNNING -> STOPPED at an edge where run=0.
REQ-016 On the STOPPED->RUNNING edge, counter SHALL load the reload register and tick SHALL be 0.
REQ-017 In RUNNING with run=1: counter != 0 -> counter decrements, tick<=0; counter == 0 -> counter reloads, tick<=1.
REQ-018 First tick after entering RUNNING SHALL be high in the cycle following edge reload+1 after the entering edge; subsequent ticks every reload+1 cycles.
REQ-019 reload = 0 in RUNNING SHALL give tick continuously high starting in the cycle after edge 1.
REQ-020 On the RUNNING->STOPPED edge, tick<=0 and counter SHALL hold its value.
REQ-021 step edge detector: register step_d <= step every edge; step_rise = step & ~step_d.
REQ-022 In STOPPED: tick <= step_rise (exactly one pulse per step rising edge); counter holds.
REQ-023 In RUNNING, step SHALL be ignored; step_d still updates.
REQ-024 load=1 at an edge SHALL write loadValue into the reload register; the running count is not disturbed; new value used from the next reload.
REQ-025 load coincident with a reload or a STOPPED->RUNNING edge: counter SHALL take the old reload register value.
REQ-026 tickCount SHALL increment at every edge where tick is set to 1, wrapping from all-ones to 0.
REQ-027 clearCount=1 SHALL set tickCount to 0 at that edge, with priority over a coincident increment.
REQ-028 counter arithmetic SHALL be unsigned nrOfBits; no underflow (reload at 0).

Reset
REQ-029 reset=1 SHALL immediately, independent of s_clock: state=STOPPED, counter=reloadValue, reload register=reloadValue, tick=0, running=0, tickCount=0, step_d=0.
REQ-030 reset asserted mid-RUNNING SHALL force tick low at once; after release the block stays STOPPED until run=1 is sampled.
REQ-031 reset has priority over all other inputs.

Verification
REQ-032 reloadValue=3, run held 1 from edge 0 -> tick high after edges 4, 8, 12 (one cycle each); tickCount=3 after edge 12.
REQ-033 run=0, step pulsed high 3 cycles then low, twice -> exactly 2 one-cycle tick pulses, tickCount=2, running=0 throughout.
REQ-034 reloadValue=3 running, load=1 loadValue=1 at edge 2 -> current period ends at edge 4; following ticks after edges 6, 8.
REQ-035 load loadValue=0, run=1 -> tick continuously high from the cycle after edge 1; tickCount wraps 255->0 with tickCountBits=8.
REQ-036 reset asserted between edges while tick=1 and running=1 -> tick, running, tickCount = 0 before next edge; no tick after release with run=0.
REQ-037 clearCount=1 on an edge that issues a tick -> tickCount=0, tick=1.

Source files
------------

// File: rtl/tick_generator.sv
// tick_generator: programmable clock-enable source with free-running and
// single-step modes, a runtime-loadable reload register and a tick counter.
module tick_generator #(
  parameter int unsigned nrOfBits      = 16,
  parameter int unsigned reloadValue   = 9999,
  parameter int unsigned tickCountBits = 8
) (
  input  logic                     reset,
  input  logic                     s_clock,
  input  logic                     run,
  input  logic                     step,
  input  logic                     load,
  input  logic [nrOfBits-1:0]      loadValue,
  input  logic                     clearCount,
  output logic                     tick,
  output logic                     running,
  output logic [tickCountBits-1:0] tickCount
);

  localparam logic [nrOfBits-1:0] RELOAD_INIT = nrOfBits'(reloadValue);

  typedef enum logic {
    STOPPED = 1'b0,
    RUNNING = 1'b1
  } state_t;

  state_t                   r_state;
  logic [nrOfBits-1:0]      r_counter;
  logic [nrOfBits-1:0]      r_reload;
  logic                     r_step_d;
  logic                     r_tick;
  logic [tickCountBits-1:0] r_tick_count;

  logic                     w_step_rise;
  logic                     w_counter_zero;
  logic                     w_tick_set;

  assign w_step_rise    = step & ~r_step_d;
  assign w_counter_zero = (r_counter == '0);

  // A tick is issued either by a step edge while stopped, or by period expiry
  // while running; the entering/leaving edges of RUNNING never tick.
  assign w_tick_set = (r_state == STOPPED) ? (~run & w_step_rise)
                                           : (run & w_counter_zero);

  assign tick      = r_tick;
  assign running   = (r_state == RUNNING);
  assign tickCount = r_tick_count;

  // Run/stop state machine with the divider counter and the registered tick.
  always_ff @(posedge s_clock or posedge reset) begin
    if (reset) begin
      r_state   <= STOPPED;
      r_counter <= RELOAD_INIT;
      r_tick    <= 1'b0;
    end else begin
      r_tick <= w_tick_set;
      case (r_state)
        STOPPED: begin
          if (run) begin
            r_state   <= RUNNING;
            r_counter <= r_reload;
          end
        end
        RUNNING: begin
          if (!run) begin
            r_state <= STOPPED;
          end else if (w_counter_zero) begin
            r_counter <= r_reload;
          end else begin
            r_counter <= r_counter - nrOfBits'(1);
          end
        end
      endcase
    end
  end

  // Reload register; a coincident reload still sees the old value.
  always_ff @(posedge s_clock or posedge reset) begin
    if (reset) begin
      r_reload <= RELOAD_INIT;
    end else if (load) begin
      r_reload <= loadValue;
    end
  end

  // Previous step level for rising-edge detection.
  always_ff @(posedge s_clock or posedge reset) begin
    if (reset) begin
      r_step_d <= 1'b0;
    end else begin
      r_step_d <= step;
    end
  end

  // Issued-tick counter; clear wins over a coincident increment.
  always_ff @(posedge s_clock or posedge reset) begin
    if (reset) begin
      r_tick_count <= '0;
    end else if (clearCount) begin
      r_tick_count <= '0;
    end else if (w_tick_set) begin
      r_tick_count <= r_tick_count + tickCountBits'(1);
    end
  end

endmodule

// File: tb/tb_tick_generator.sv
// Bench for tick_generator: directed scenarios plus random traffic, checked
// against an edge-number based reference model through a scoreboard queue.
module tb_tick_generator;

  localparam int unsigned NB  = 16;
  localparam int unsigned RV  = 3;
  localparam int unsigned TCB = 8;

  logic           reset;
  logic           s_clock;
  logic           run;
  logic           step;
  logic           load;
  logic [NB-1:0]  loadValue;
  logic           clearCount;
  logic           tick;
  logic           running;
  logic [TCB-1:0] tickCount;

  tick_generator #(
    .nrOfBits     (NB),
    .reloadValue  (RV),
    .tickCountBits(TCB)
  ) dut (
    .reset     (reset),
    .s_clock   (s_clock),
    .run       (run),
    .step      (step),
    .load      (load),
    .loadValue (loadValue),
    .clearCount(clearCount),
    .tick      (tick),
    .running   (running),
    .tickCount (tickCount)
  );

  initial s_clock = 1'b0;
  always #5 s_clock = ~s_clock;

  typedef struct packed {
    logic           tick;
    logic           running;
    logic [TCB-1:0] count;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  // Reference model: ticks scheduled by absolute edge number.
  bit  m_running;
  int  m_reload;
  int  m_next_tick;
  bit  m_step_prev;
  int  m_count;
  int  m_edge;

  task automatic check(input string name, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_errors++;
      $display("FAIL %s: actual=%0d required=%0d at %0t", name, act, req, $time);
    end
  endtask

  task automatic model_reset();
    m_running   = 1'b0;
    m_reload    = int'(RV);
    m_next_tick = 0;
    m_step_prev = 1'b0;
    m_count     = 0;
  endtask

  task automatic model_edge(input bit r, input bit s, input bit ld,
                            input int lv, input bit c, output exp_t e);
    bit t;
    t = 1'b0;
    m_edge++;
    if (!m_running) begin
      if (r) begin
        m_running   = 1'b1;
        m_next_tick = m_edge + m_reload + 1;
      end else begin
        t = s && !m_step_prev;
      end
    end else begin
      if (!r) begin
        m_running = 1'b0;
      end else if (m_edge == m_next_tick) begin
        t           = 1'b1;
        m_next_tick = m_edge + m_reload + 1;
      end
    end
    if (ld) m_reload = lv;
    m_step_prev = s;
    if (c) m_count = 0;
    else if (t) m_count = (m_count + 1) % (1 << TCB);
    e.tick    = t;
    e.running = m_running;
    e.count   = TCB'(m_count);
  endtask

  // Drive one edge's inputs and queue the response expected after it.
  task automatic drive(input bit r, input bit s, input bit ld,
                       input int lv, input bit c);
    exp_t e;
    @(negedge s_clock);
    run        = r;
    step       = s;
    load       = ld;
    loadValue  = NB'(lv);
    clearCount = c;
    model_edge(r, s, ld, lv, c, e);
    sb_q.push_back(e);
  endtask

  // Asynchronous reset between edges; outputs must clear before any edge.
  task automatic do_reset();
    @(negedge s_clock);
    #1;
    run = 1'b0; step = 1'b0; load = 1'b0; loadValue = '0; clearCount = 1'b0;
    reset = 1'b1;
    #1;
    check("reset_tick", int'(tick), 0);
    check("reset_running", int'(running), 0);
    check("reset_count", int'(tickCount), 0);
    model_reset();
    @(negedge s_clock);
    reset = 1'b0;
  endtask

  // Monitor: every edge with a queued expectation is compared.
  initial begin
    exp_t e;
    forever begin
      @(posedge s_clock);
      #1;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        check("tick", int'(tick), int'(e.tick));
        check("running", int'(running), int'(e.running));
        check("tickCount", int'(tickCount), int'(e.count));
      end
    end
  end

  initial begin
    bit r_lvl;
    reset = 1'b1; run = 1'b0; step = 1'b0; load = 1'b0;
    loadValue = '0; clearCount = 1'b0;
    m_edge = 0;
    model_reset();
    #2;
    check("por_tick", int'(tick), 0);
    check("por_running", int'(running), 0);
    check("por_count", int'(tickCount), 0);
    @(negedge s_clock);
    reset = 1'b0;

    // Free running with the reset reload value.
    for (int i = 0; i < 14; i++) drive(1, 0, 0, 0, 0);

    // Stopped single-step: two 3-cycle step pulses.
    drive(0, 0, 0, 0, 0);
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 3; i++) drive(0, 1, 0, 0, 0);
      for (int i = 0; i < 3; i++) drive(0, 0, 0, 0, 0);
    end

    // Reload change during a running period.
    do_reset();
    drive(1, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0);
    drive(1, 0, 1, 1, 0);
    for (int i = 0; i < 8; i++) drive(1, 0, 0, 0, 0);

    // Reload of zero: continuous ticks, a clear on a tick edge, count wrap.
    drive(0, 0, 1, 0, 0);
    for (int i = 0; i < 300; i++) drive(1, 0, 0, 0, (i == 10));

    // Reset while tick is high, then remain stopped.
    do_reset();
    for (int i = 0; i < 6; i++) drive(0, 0, 0, 0, 0);

    // Random traffic with a reset in the middle.
    r_lvl = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 15) == 0) r_lvl = ~r_lvl;
      if (i == 1000) do_reset();
      drive(r_lvl, 1'($urandom_range(0, 1)), ($urandom_range(0, 7) == 0),
            int'($urandom_range(0, 6)), ($urandom_range(0, 15) == 0));
    end

    @(negedge s_clock);
    @(negedge s_clock);
    check("scoreboard_drained", sb_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
